rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: the load/store unit (LSU) and the ALU. It arbitrates them round-robin with a valid/ready handshake and registers the winner onto the register file write port. It also produces a bypass result for the two read ports, because the register file's synchronous read returns the stale value when a read and a write to the same register hit the same edge. It sits between the execute/memory stages and the register file.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rf_wb_arbiter_if.sv | 56 +++++
 rtl/rf_wb_arbiter_rr_arb2.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 83 ++++++++
 tb/tb_rf_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the register-file writeback path.
//   XLEN     : data width of a writeback
//   REG_AW   : register address width (32 architectural registers)
//   wb_req_t : one writeback request as presented by a requester
//   PRIO_*   : values of the round-robin pointer naming the favoured requester
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  localparam logic PRIO_LSU = 1'b0;
  localparam logic PRIO_ALU = 1'b1;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus between the writeback requesters, the register file and rf_wb_arbiter.
//   lsu_* / alu_* : writeback requests and their ready
//   rf_w_*        : registered register-file write port
//   rd_addr1/2    : register-file read addresses (also seen by the arbiter)
//   byp_*         : bypass result aligned with the register-file read data
//   prio          : round-robin pointer, exposed for observation
// Handshake: a request transfers on a rising edge where valid && ready.
// Once valid is raised it stays high with stable rd/data until that edge;
// ready may depend combinationally on both valids and never on ready.
interface rf_wb_arbiter_if import rv_pkg::*; ();

  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              rf_w_en;
  logic [REG_AW-1:0] rf_w_reg;
  logic [XLEN-1:0]   rf_w_data;

  logic [REG_AW-1:0] rd_addr1;
  logic [REG_AW-1:0] rd_addr2;

  logic              byp_hit1;
  logic [XLEN-1:0]   byp_data1;
  logic              byp_hit2;
  logic [XLEN-1:0]   byp_data2;

  logic              prio;

  modport slave (
    input  lsu_valid, lsu_rd, lsu_data,
    input  alu_valid, alu_rd, alu_data,
    input  rd_addr1, rd_addr2,
    output lsu_ready, alu_ready,
    output rf_w_en, rf_w_reg, rf_w_data,
    output byp_hit1, byp_data1, byp_hit2, byp_data2,
    output prio
  );

  modport master (
    output lsu_valid, lsu_rd, lsu_data,
    output alu_valid, alu_rd, alu_data,
    output rd_addr1, rd_addr2,
    input  lsu_ready, alu_ready,
    input  rf_w_en, rf_w_reg, rf_w_data,
    input  byp_hit1, byp_data1, byp_hit2, byp_data2,
    input  prio
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
//   clk, rstn : clock, asynchronous active-low reset
//   req[1:0]  : requests, bit 0 = LSU, bit 1 = ALU
//   gnt[1:0]  : one-hot (or zero) grant, combinational from req and prio
//   prio      : pointer naming the favoured requester (PRIO_LSU / PRIO_ALU)
module rr_arb2 import rv_pkg::*; (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  // A lone requester wins outright; the pointer only matters under contention.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == PRIO_ALU) ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves only when both competed, and then favours the loser.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio <= PRIO_LSU;
    end else if (req == 2'b11) begin
      prio <= gnt[0] ? PRIO_ALU : PRIO_LSU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the LSU and the ALU.
// Requests are arbitrated round-robin, the winner is registered onto the
// write port, and a one-cycle bypass covers the read that lands on the same
// edge as the register-file write (the file would return stale data there).
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : rf_wb_arbiter_if.slave (requests, write port, read addrs, bypass)
module rf_wb_arbiter import rv_pkg::*; (
  input  logic                  clk,
  input  logic                  rstn,
  rf_wb_arbiter_if.slave        bus
);

  wb_req_t           lsu_req;
  wb_req_t           alu_req;
  wb_req_t           win;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              prio;
  logic              xfer;

  logic              w_en;
  logic [REG_AW-1:0] w_reg;
  logic [XLEN-1:0]   w_data;
  logic              hit1;
  logic              hit2;
  logic [XLEN-1:0]   bdata1;
  logic [XLEN-1:0]   bdata2;

  assign lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};
  assign alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
  assign req     = {alu_req.valid, lsu_req.valid};

  rr_arb2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .gnt  (gnt),
    .prio (prio)
  );

  // Ready is held low during reset so no requester believes it was accepted.
  assign bus.lsu_ready = gnt[0] & rstn;
  assign bus.alu_ready = gnt[1] & rstn;

  assign xfer = |gnt;
  assign win  = gnt[1] ? alu_req : lsu_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_en   <= 1'b0;
      w_reg  <= '0;
      w_data <= '0;
      hit1   <= 1'b0;
      hit2   <= 1'b0;
      bdata1 <= '0;
      bdata2 <= '0;
    end else begin
      // Writes to x0 complete the handshake but never enable the write.
      w_en <= xfer && (win.rd != '0);
      if (xfer) begin
        w_reg  <= win.rd;
        w_data <= win.data;
      end
      // The register file commits w_reg/w_data on this same edge, so its
      // read data for a matching address is stale; flag it for the consumer.
      hit1   <= w_en && (w_reg == bus.rd_addr1) && (bus.rd_addr1 != '0);
      hit2   <= w_en && (w_reg == bus.rd_addr2) && (bus.rd_addr2 != '0);
      bdata1 <= w_data;
      bdata2 <= w_data;
    end
  end

  assign bus.rf_w_en   = w_en;
  assign bus.rf_w_reg  = w_reg;
  assign bus.rf_w_data = w_data;
  assign bus.byp_hit1  = hit1;
  assign bus.byp_data1 = bdata1;
  assign bus.byp_hit2  = hit2;
  assign bus.byp_data2 = bdata2;
  assign bus.prio      = prio;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Inputs change and outputs are sampled on
// the falling clock edge; registered results of a rising edge are therefore
// visible at the following falling edge.
module tb_rf_wb_arbiter;
  import rv_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.rd_addr1  = '0;
    bus.rd_addr2  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    tick();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    bus.lsu_valid = 1'b1;
    bus.alu_valid = 1'b1;
    tick();
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b0 || bus.rf_w_reg !== '0 || bus.rf_w_data !== '0) begin
      n_fail++;
      $display("FAIL reset_wport: en=%b reg=%0d data=%h, expected 0/0/0",
               bus.rf_w_en, bus.rf_w_reg, bus.rf_w_data);
    end
    n_checks++;
    if (bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0 ||
        bus.byp_data1 !== '0 || bus.byp_data2 !== '0) begin
      n_fail++;
      $display("FAIL reset_bypass: hit1=%b hit2=%b d1=%h d2=%h, expected all 0",
               bus.byp_hit1, bus.byp_hit2, bus.byp_data1, bus.byp_data2);
    end
    n_checks++;
    if (bus.lsu_ready !== 1'b0 || bus.alu_ready !== 1'b0 || bus.prio !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: lsu_ready=%b alu_ready=%b prio=%b, expected 0/0/0",
               bus.lsu_ready, bus.alu_ready, bus.prio);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_lsu_only();
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd5;
    bus.lsu_data  = 64'hA5;
    #1;
    n_checks++;
    if (bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lsu_only_ready: lsu_ready=%b alu_ready=%b, expected 1/0",
               bus.lsu_ready, bus.alu_ready);
    end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b1 || bus.rf_w_reg !== 5'd5 || bus.rf_w_data !== 64'hA5) begin
      n_fail++;
      $display("FAIL lsu_only_write: en=%b reg=%0d data=%h, expected 1/5/a5",
               bus.rf_w_en, bus.rf_w_reg, bus.rf_w_data);
    end
    tick();
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b0 || bus.rf_w_reg !== 5'd5 || bus.rf_w_data !== 64'hA5) begin
      n_fail++;
      $display("FAIL lsu_only_hold: en=%b reg=%0d data=%h, expected 0/5/a5",
               bus.rf_w_en, bus.rf_w_reg, bus.rf_w_data);
    end
  endtask

  task automatic test_contention();
    // Per cycle: inputs presented, expected LSU grant, expected write reg,
    // expected pointer after the edge.
    logic [3:0] t_lsu_v    = 4'b0111;
    logic [4:0] t_lsu_rd [4] = '{5'd3, 5'd4, 5'd4, 5'd0};
    logic [4:0] t_alu_rd [4] = '{5'd1, 5'd1, 5'd2, 5'd2};
    logic [3:0] t_gnt_lsu  = 4'b0101;
    logic [4:0] t_reg  [4] = '{5'd3, 5'd1, 5'd4, 5'd2};
    logic [3:0] t_prio     = 4'b1101;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.lsu_valid = t_lsu_v[i];
      bus.lsu_rd    = t_lsu_rd[i];
      bus.lsu_data  = 64'h100 + 64'(t_lsu_rd[i]);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = t_alu_rd[i];
      bus.alu_data  = 64'h200 + 64'(t_alu_rd[i]);
      #1;
      n_checks++;
      if (bus.lsu_ready !== t_gnt_lsu[i] || bus.alu_ready !== ~t_gnt_lsu[i]) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: lsu_ready=%b alu_ready=%b, expected %b/%b",
                 i, bus.lsu_ready, bus.alu_ready, t_gnt_lsu[i], ~t_gnt_lsu[i]);
      end
      tick();
      #1;
      n_checks++;
      if (bus.rf_w_en !== 1'b1 || bus.rf_w_reg !== t_reg[i] ||
          bus.rf_w_data !== ((t_gnt_lsu[i] ? 64'h100 : 64'h200) + 64'(t_reg[i])) ||
          bus.prio !== t_prio[i]) begin
        n_fail++;
        $display("FAIL contention_write[%0d]: en=%b reg=%0d data=%h prio=%b, expected 1/%0d/-/%b",
                 i, bus.rf_w_en, bus.rf_w_reg, bus.rf_w_data, bus.prio, t_reg[i], t_prio[i]);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 64'hFF;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: alu_ready=%b, expected 1", bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_wen_1: rf_w_en=%b, expected 0", bus.rf_w_en);
    end
    tick();
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_wen_2: rf_w_en=%b, expected 0", bus.rf_w_en);
    end
  endtask

  // Accept a write at edge T via the ALU, then present read addresses
  // for edge T+1 (a1/a2) and edge T+2 (b1/b2).
  task automatic bypass_seq(input logic [4:0] rd, input logic [63:0] data,
                            input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] b1, input logic [4:0] b2);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = data;
    bus.rd_addr1  = '0;
    bus.rd_addr2  = '0;
    tick();
    bus.alu_valid = 1'b0;
    bus.rd_addr1  = a1;
    bus.rd_addr2  = a2;
    tick();
    bus.rd_addr1  = b1;
    bus.rd_addr2  = b2;
  endtask

  task automatic test_bypass();
    bypass_seq(5'd7, 64'h1234, 5'd7, 5'd8, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.byp_hit1 !== 1'b1 || bus.byp_data1 !== 64'h1234 || bus.byp_hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_t1: hit1=%b d1=%h hit2=%b, expected 1/1234/0",
               bus.byp_hit1, bus.byp_data1, bus.byp_hit2);
    end
    tick();
    bypass_seq(5'd7, 64'h5678, 5'd0, 5'd0, 5'd7, 5'd7);
    tick();
    #1;
    n_checks++;
    if (bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_t2: hit1=%b hit2=%b, expected 0/0", bus.byp_hit1, bus.byp_hit2);
    end
    bypass_seq(5'd9, 64'hBEEF, 5'd9, 5'd9, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.byp_hit1 !== 1'b1 || bus.byp_hit2 !== 1'b1 ||
        bus.byp_data1 !== 64'hBEEF || bus.byp_data2 !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL bypass_both: hit1=%b hit2=%b d1=%h d2=%h, expected 1/1/beef/beef",
               bus.byp_hit1, bus.byp_hit2, bus.byp_data1, bus.byp_data2);
    end
    tick();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd3;
    bus.lsu_data  = 64'h33;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = 64'h11;
    tick();                    // LSU rd3 accepted
    bus.lsu_rd    = 5'd4;
    bus.lsu_data  = 64'h44;
    bus.rd_addr1  = 5'd3;
    bus.rd_addr2  = 5'd3;
    tick();                    // ALU rd1 accepted, bypass of rd3
    bus.alu_rd    = 5'd2;
    bus.alu_data  = 64'h22;
    bus.rd_addr1  = 5'd1;
    bus.rd_addr2  = 5'd1;
    tick();                    // LSU rd4 accepted, bypass of rd1
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b1 || bus.byp_hit1 !== 1'b1 || bus.byp_hit2 !== 1'b1 ||
        bus.prio !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: en=%b hit1=%b hit2=%b prio=%b, expected 1/1/1/1",
               bus.rf_w_en, bus.byp_hit1, bus.byp_hit2, bus.prio);
    end
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b0 || bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0 ||
        bus.lsu_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: en=%b hit1=%b hit2=%b lrdy=%b ardy=%b, expected all 0",
               bus.rf_w_en, bus.byp_hit1, bus.byp_hit2, bus.lsu_ready, bus.alu_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_first_grant: lsu_ready=%b alu_ready=%b, expected 1/0",
               bus.lsu_ready, bus.alu_ready);
    end
    tick();
    #1;
    n_checks++;
    if (bus.rf_w_en !== 1'b1 || bus.rf_w_reg !== 5'd4 || bus.rf_w_data !== 64'h44) begin
      n_fail++;
      $display("FAIL reset_mid_write: en=%b reg=%0d data=%h, expected 1/4/44",
               bus.rf_w_en, bus.rf_w_reg, bus.rf_w_data);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    idle_inputs();
    test_reset();
    test_lsu_only();
    test_contention();
    test_x0();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
